m3_commutation_sequencer: RTL and testbench

- Six-step (trapezoidal) commutation sequencer for the 3-phase motor path.
- Sits between the power/speed calculator and the three IRS2007S half-bridge drivers.
- Takes run/brake/direction controls, a commutation step period and a PWM duty value.
- Produces one 2-bit down1_up2 drive code per phase, feeding each driver instance directly.

---
 rtl/m3_commutation_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_m3_commutation_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_commutation_sequencer.sv
// ---------------------------------------------------------------------------
// m3_commutation_sequencer
// Six-step trapezoidal commutation sequencer for the 3-phase motor path.
// Turns run/brake/direction controls, a step period and a PWM duty value into
// one 2-bit down1_up2 drive code per IRS2007S half-bridge:
//   0 = both switches off (float), 1 = low side on, 2 = high side on.
// The drive codes are registered and are computed from the state, step and
// timer values being loaded on the same edge. An input change therefore
// appears on the codes one clock later, and the codes line up with stepO and
// stateO.
// ---------------------------------------------------------------------------
module m3_commutation_sequencer #(
    parameter int PERIOD_W  = 16,
    parameter int PWM_W     = 8,
    parameter int ALIGN_CYC = 1000,
    parameter int DEAD_CYC  = 2
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic                m3startI,
    input  logic                m3forceStopI,
    input  logic                m3invRotateI,
    input  logic [PERIOD_W-1:0] stepPeriodI,
    input  logic [PWM_W-1:0]    dutyI,
    output logic [1:0]          aDown1Up2O,
    output logic [1:0]          bDown1Up2O,
    output logic [1:0]          cDown1Up2O,
    output logic [2:0]          stepO,
    output logic [1:0]          stateO,
    output logic                stepTickO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    localparam int ALIGN_W = (ALIGN_CYC > 1) ? $clog2(ALIGN_CYC) : 1;
    localparam logic [ALIGN_W-1:0]  ALIGN_LAST  = ALIGN_W'(ALIGN_CYC - 1);
    localparam logic [PERIOD_W-1:0] DEAD_LEN    = PERIOD_W'(DEAD_CYC);
    // Shortest usable step: the dead gap plus two driven clocks.
    localparam logic [PERIOD_W-1:0] MIN_PERIOD  = PERIOD_W'(DEAD_CYC + 2);
    // A step always starts at timer 0, so it starts inside the gap whenever
    // a gap exists at all.
    localparam logic                GAP_AT_ZERO = (DEAD_CYC > 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] CODE_FLOAT = 2'd0;
    localparam logic [1:0] CODE_LOW   = 2'd1;
    localparam logic [1:0] CODE_HIGH  = 2'd2;

    // Table pattern {A,B,C} for one step. The up phase is chopped by the PWM.
    // The down phase is held low. The remaining phase floats.
    function automatic logic [5:0] stepPattern(input logic [2:0] stp,
                                               input logic       pwmOn);
        logic [1:0] up;
        up = pwmOn ? CODE_HIGH : CODE_FLOAT;
        case (stp)
            3'd0:    stepPattern = {up,         CODE_LOW,   CODE_FLOAT};
            3'd1:    stepPattern = {up,         CODE_FLOAT, CODE_LOW};
            3'd2:    stepPattern = {CODE_FLOAT, up,         CODE_LOW};
            3'd3:    stepPattern = {CODE_LOW,   up,         CODE_FLOAT};
            3'd4:    stepPattern = {CODE_LOW,   CODE_FLOAT, up};
            3'd5:    stepPattern = {CODE_FLOAT, CODE_LOW,   up};
            default: stepPattern = {CODE_FLOAT, CODE_FLOAT, CODE_FLOAT};
        endcase
    endfunction

    // Next step index, modulo 6, in either rotation direction.
    function automatic logic [2:0] nextStepIdx(input logic [2:0] stp,
                                               input logic       rev);
        case (stp)
            3'd0:    nextStepIdx = rev ? 3'd5 : 3'd1;
            3'd1:    nextStepIdx = rev ? 3'd0 : 3'd2;
            3'd2:    nextStepIdx = rev ? 3'd1 : 3'd3;
            3'd3:    nextStepIdx = rev ? 3'd2 : 3'd4;
            3'd4:    nextStepIdx = rev ? 3'd3 : 3'd5;
            3'd5:    nextStepIdx = rev ? 3'd4 : 3'd0;
            default: nextStepIdx = 3'd0;
        endcase
    endfunction

    // Full drive code set {A,B,C} for the state/step/timer being entered.
    // Code 3 cannot come out of this function.
    function automatic logic [5:0] driveCodes(input state_t     st,
                                              input logic [2:0] stp,
                                              input logic       inGap,
                                              input logic       pwmOn);
        case (st)
            ST_IDLE:  driveCodes = {CODE_FLOAT, CODE_FLOAT, CODE_FLOAT};
            ST_ALIGN: driveCodes = stepPattern(3'd0, pwmOn);
            ST_RUN:   driveCodes = inGap ? {CODE_FLOAT, CODE_FLOAT, CODE_FLOAT}
                                         : stepPattern(stp, pwmOn);
            ST_BRAKE: driveCodes = {CODE_LOW, CODE_LOW, CODE_LOW};
            default:  driveCodes = {CODE_FLOAT, CODE_FLOAT, CODE_FLOAT};
        endcase
    endfunction

    state_t              state_r;
    logic [2:0]          step_r;
    logic [PERIOD_W-1:0] timer_r;
    logic [PERIOD_W-1:0] periodLat_r;
    logic [PWM_W-1:0]    pwmCnt_r;
    logic [ALIGN_W-1:0]  alignCnt_r;

    logic                pwmOn_s;
    logic [PERIOD_W-1:0] periodClamp_s;
    logic [PERIOD_W-1:0] timerInc_s;
    logic                gapInc_s;
    logic                stepLast_s;
    logic [2:0]          stepAdv_s;

    assign pwmOn_s       = (pwmCnt_r < dutyI);
    assign periodClamp_s = (stepPeriodI < MIN_PERIOD) ? MIN_PERIOD : stepPeriodI;
    assign timerInc_s    = timer_r + PERIOD_W'(1);
    assign gapInc_s      = (timerInc_s < DEAD_LEN);
    // periodLat_r is never below MIN_PERIOD while in RUN, so the subtraction
    // cannot wrap there.
    assign stepLast_s    = (timer_r == (periodLat_r - PERIOD_W'(1)));
    assign stepAdv_s     = nextStepIdx(step_r, m3invRotateI);

    // stepO and stateO come straight from their registers, so they line up
    // with the registered drive codes.
    assign stepO  = step_r;
    assign stateO = state_r;

    // Sequencer FSM: PWM counter, state/step/timer update, registered codes.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_r     <= ST_IDLE;
            step_r      <= 3'd0;
            timer_r     <= {PERIOD_W{1'b0}};
            periodLat_r <= {PERIOD_W{1'b0}};
            pwmCnt_r    <= {PWM_W{1'b0}};
            alignCnt_r  <= {ALIGN_W{1'b0}};
            aDown1Up2O  <= CODE_FLOAT;
            bDown1Up2O  <= CODE_FLOAT;
            cDown1Up2O  <= CODE_FLOAT;
            stepTickO   <= 1'b0;
        end else begin
            pwmCnt_r  <= pwmCnt_r + PWM_W'(1);
            stepTickO <= 1'b0;
            if (m3forceStopI) begin
                // Brake overrides everything. The step is kept for reference.
                state_r <= ST_BRAKE;
                {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                    driveCodes(ST_BRAKE, step_r, 1'b0, pwmOn_s);
            end else if (!m3startI || (state_r == ST_BRAKE)) begin
                // Coast. Leaving brake always passes through IDLE, even
                // when start is still asserted.
                state_r <= ST_IDLE;
                {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                    driveCodes(ST_IDLE, step_r, 1'b0, pwmOn_s);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r    <= ST_ALIGN;
                        step_r     <= 3'd0;
                        alignCnt_r <= {ALIGN_W{1'b0}};
                        {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                            driveCodes(ST_ALIGN, 3'd0, 1'b0, pwmOn_s);
                    end
                    ST_ALIGN: begin
                        if (alignCnt_r == ALIGN_LAST) begin
                            state_r     <= ST_RUN;
                            timer_r     <= {PERIOD_W{1'b0}};
                            periodLat_r <= periodClamp_s;
                            {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                                driveCodes(ST_RUN, step_r, GAP_AT_ZERO, pwmOn_s);
                        end else begin
                            alignCnt_r <= alignCnt_r + ALIGN_W'(1);
                            {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                                driveCodes(ST_ALIGN, 3'd0, 1'b0, pwmOn_s);
                        end
                    end
                    ST_RUN: begin
                        if (stepLast_s) begin
                            // Step boundary: direction and period are sampled
                            // only here.
                            step_r      <= stepAdv_s;
                            timer_r     <= {PERIOD_W{1'b0}};
                            periodLat_r <= periodClamp_s;
                            stepTickO   <= 1'b1;
                            {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                                driveCodes(ST_RUN, stepAdv_s, GAP_AT_ZERO, pwmOn_s);
                        end else begin
                            timer_r <= timerInc_s;
                            {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                                driveCodes(ST_RUN, step_r, gapInc_s, pwmOn_s);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        {aDown1Up2O, bDown1Up2O, cDown1Up2O} <=
                            driveCodes(ST_IDLE, step_r, 1'b0, pwmOn_s);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m3_commutation_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for m3_commutation_sequencer.
// `cyc` counts rising edges since reset release. The sample taken after edge
// n shows the PWM counter value n-1, because the counter starts at 0 and
// advances once per edge.
// ---------------------------------------------------------------------------
module tb_m3_commutation_sequencer;

    logic        clkI = 1'b0;
    logic        nRstI;
    logic        m3startI;
    logic        m3forceStopI;
    logic        m3invRotateI;
    logic [15:0] stepPeriodI;
    logic [7:0]  dutyI;
    logic [1:0]  aDown1Up2O;
    logic [1:0]  bDown1Up2O;
    logic [1:0]  cDown1Up2O;
    logic [2:0]  stepO;
    logic [1:0]  stateO;
    logic        stepTickO;

    int vecCnt = 0;
    int errCnt = 0;
    int cyc    = 0;
    int onCnt;
    int badCnt;

    m3_commutation_sequencer #(
        .PERIOD_W (16),
        .PWM_W    (8),
        .ALIGN_CYC(1000),
        .DEAD_CYC (2)
    ) dut (
        .clkI        (clkI),
        .nRstI       (nRstI),
        .m3startI    (m3startI),
        .m3forceStopI(m3forceStopI),
        .m3invRotateI(m3invRotateI),
        .stepPeriodI (stepPeriodI),
        .dutyI       (dutyI),
        .aDown1Up2O  (aDown1Up2O),
        .bDown1Up2O  (bDown1Up2O),
        .cDown1Up2O  (cDown1Up2O),
        .stepO       (stepO),
        .stateO      (stateO),
        .stepTickO   (stepTickO)
    );

    always #5 clkI = ~clkI;

    // Expected up-phase code for the sample taken after edge n.
    function automatic logic [1:0] expUp(input int n, input int duty);
        return (((n - 1) % 256) < duty) ? 2'd2 : 2'd0;
    endfunction

    // Commutation table {A,B,C}: (up, down, float) per step.
    function automatic logic [5:0] expCodes(input logic [2:0] s, input logic [1:0] up);
        case (s)
            3'd0:    return {up, 2'd1, 2'd0};
            3'd1:    return {up, 2'd0, 2'd1};
            3'd2:    return {2'd0, up, 2'd1};
            3'd3:    return {2'd1, up, 2'd0};
            3'd4:    return {2'd1, 2'd0, up};
            3'd5:    return {2'd0, 2'd1, up};
            default: return 6'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkCodes(input string tag, input logic [5:0] exp);
        chk({tag, "_codes"}, {26'd0, aDown1Up2O, bDown1Up2O, cDown1Up2O}, {26'd0, exp});
    endtask

    task automatic chkSt(input string tag, input logic [1:0] st, input logic [2:0] sp);
        chk({tag, "_state"}, {30'd0, stateO}, {30'd0, st});
        chk({tag, "_step"},  {29'd0, stepO},  {29'd0, sp});
    endtask

    task automatic chkTick(input string tag, input logic t);
        chk({tag, "_tick"}, {31'd0, stepTickO}, {31'd0, t});
    endtask

    task automatic tickTo(input int target);
        while (cyc < target) begin
            @(posedge clkI);
            #1;
            cyc++;
        end
    endtask

    initial begin
        // Reset with every input high.
        nRstI        = 1'b0;
        m3startI     = 1'b1;
        m3forceStopI = 1'b1;
        m3invRotateI = 1'b1;
        stepPeriodI  = 16'hFFFF;
        dutyI        = 8'hFF;
        #23;
        chkCodes("reset", 6'd0);
        chkSt("reset", 2'd0, 3'd0);
        chkTick("reset", 1'b0);

        m3startI     = 1'b0;
        m3forceStopI = 1'b0;
        m3invRotateI = 1'b0;
        stepPeriodI  = 16'd10;
        dutyI        = 8'd255;
        @(posedge clkI);
        #1;
        nRstI = 1'b1;
        cyc   = 0;

        tickTo(3);
        chkSt("idle_hold", 2'd0, 3'd0);
        chkCodes("idle_hold", 6'd0);

        // Alignment: s0 pattern for 1000 clocks.
        m3startI = 1'b1;
        tickTo(4);
        chkSt("align_entry", 2'd1, 3'd0);
        chkCodes("align_entry", {expUp(4, 255), 2'd1, 2'd0});
        tickTo(767);
        chkCodes("align_pwm_on", {2'd2, 2'd1, 2'd0});
        tickTo(768);
        chkCodes("align_pwm_wrap", {2'd0, 2'd1, 2'd0});
        tickTo(1003);
        chkSt("align_last", 2'd1, 3'd0);

        // RUN, forward, period 10.
        tickTo(1004);
        chkSt("run_entry", 2'd2, 3'd0);
        chkCodes("run_dead0", 6'd0);
        chkTick("run_entry", 1'b0);
        tickTo(1005);
        chkCodes("run_dead1", 6'd0);
        tickTo(1006);
        chkCodes("run_drive", expCodes(3'd0, expUp(1006, 255)));
        for (int k = 1; k <= 6; k++) begin
            tickTo(1003 + 10 * k);
            chkSt("fwd_before", 2'd2, 3'((k - 1) % 6));
            chkTick("fwd_before", 1'b0);
            tickTo(1004 + 10 * k);
            chkSt("fwd_adv", 2'd2, 3'(k % 6));
            chkTick("fwd_adv", 1'b1);
            chkCodes("fwd_adv_dead", 6'd0);
            tickTo(1006 + 10 * k);
            chkCodes("fwd_pattern", expCodes(3'(k % 6), expUp(1006 + 10 * k, 255)));
        end

        // Reverse requested mid-step; takes effect only at the next boundary.
        m3invRotateI = 1'b1;
        tickTo(1073);
        chkSt("rev_pending", 2'd2, 3'd0);
        tickTo(1074);
        chkSt("rev_adv", 2'd2, 3'd5);
        chkTick("rev_adv", 1'b1);
        tickTo(1084);
        chkSt("rev_adv2", 2'd2, 3'd4);

        // Long step so a whole PWM frame fits outside the gap.
        tickTo(1090);
        stepPeriodI = 16'd400;
        dutyI       = 8'd64;
        tickTo(1094);
        chkSt("long_step", 2'd2, 3'd3);
        tickTo(1099);
        onCnt  = 0;
        badCnt = 0;
        while (cyc < 1355) begin
            tickTo(cyc + 1);
            if (bDown1Up2O === 2'd2) onCnt++;
            if ((aDown1Up2O !== 2'd1) || (cDown1Up2O !== 2'd0)) badCnt++;
        end
        chk("duty64_on_count", onCnt, 64);
        chk("duty64_other_phases", badCnt, 0);

        tickTo(1360);
        dutyI = 8'd0;
        tickTo(1361);
        onCnt = 0;
        while (cyc < 1490) begin
            tickTo(cyc + 1);
            if (bDown1Up2O === 2'd2) onCnt++;
        end
        chk("duty0_on_count", onCnt, 0);

        // Brake mid-RUN.
        tickTo(1494);
        chkSt("pre_brake", 2'd2, 3'd2);
        tickTo(1500);
        m3forceStopI = 1'b1;
        tickTo(1501);
        chkSt("brake", 2'd3, 3'd2);
        chkCodes("brake", {2'd1, 2'd1, 2'd1});
        tickTo(1505);
        chkCodes("brake_hold", {2'd1, 2'd1, 2'd1});
        m3forceStopI = 1'b0;
        tickTo(1506);
        chkSt("brake_release", 2'd0, 3'd2);
        chkCodes("brake_release", 6'd0);
        tickTo(1507);
        chkSt("realign", 2'd1, 3'd0);
        chkCodes("realign", {2'd0, 2'd1, 2'd0});

        // Period clamp: 0 and 3 both give 4-clock steps.
        tickTo(1510);
        stepPeriodI = 16'd0;
        dutyI       = 8'd255;
        tickTo(2506);
        chkSt("realign_last", 2'd1, 3'd0);
        tickTo(2507);
        chkSt("clamp_entry", 2'd2, 3'd0);
        tickTo(2509);
        chkCodes("clamp_drive", expCodes(3'd0, expUp(2509, 255)));
        tickTo(2510);
        chkSt("clamp0_last", 2'd2, 3'd0);
        chkTick("clamp0_last", 1'b0);
        tickTo(2511);
        chkSt("clamp0_adv", 2'd2, 3'd5);
        chkTick("clamp0_adv", 1'b1);
        tickTo(2515);
        chkSt("clamp0_adv2", 2'd2, 3'd4);
        tickTo(2516);
        stepPeriodI = 16'd3;
        tickTo(2519);
        chkSt("clamp3_entry", 2'd2, 3'd3);
        chkCodes("clamp3_dead", 6'd0);
        tickTo(2521);
        chkCodes("clamp3_drive", expCodes(3'd3, expUp(2521, 255)));
        tickTo(2522);
        chkSt("clamp3_last", 2'd2, 3'd3);
        tickTo(2523);
        chkSt("clamp3_adv", 2'd2, 3'd2);
        chkTick("clamp3_adv", 1'b1);

        // Start dropped mid-step: coast next cycle, step retained.
        tickTo(2525);
        chkCodes("pre_coast", expCodes(3'd2, expUp(2525, 255)));
        m3startI = 1'b0;
        tickTo(2526);
        chkSt("coast", 2'd0, 3'd2);
        chkCodes("coast", 6'd0);

        // Asynchronous reset in the middle of ALIGN.
        m3startI = 1'b1;
        tickTo(2528);
        chkSt("pre_reset", 2'd1, 3'd0);
        #2;
        nRstI = 1'b0;
        #1;
        chkSt("async_reset", 2'd0, 3'd0);
        chkCodes("async_reset", 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
